// File: rtl/execute_stage_if.sv
// DX -> EX -> XM bundle for the GCD CPU execute stage.
// The decode side drives the DX fields and run state. The execute stage
// returns the XM registers, the front-end stall and the fetch redirect.
interface execute_stage_if;
  // CPU run state; 2'b01 is RUN
  logic [1:0]  curr_state;

  // DX pipeline registers
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        branch;
  logic        jump;
  logic        Jal_swit;
  logic        JR_swit;
  logic [2:0]  ALUctr;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] MD;
  logic [31:0] JT;
  logic [31:0] DX_PC;
  logic [15:0] imm;
  logic [4:0]  RD;

  // XM pipeline registers
  logic        XM_MemtoReg;
  logic        XM_RegWrite;
  logic        XM_MemRead;
  logic        XM_MemWrite;
  logic [31:0] XM_ALUout;
  logic [31:0] XM_MD;
  logic [4:0]  XM_RD;

  // Front-end control
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output curr_state, MemtoReg, RegWrite, MemRead, MemWrite,
           branch, jump, Jal_swit, JR_swit, ALUctr,
           A, B, MD, JT, DX_PC, imm, RD,
    input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite,
           XM_ALUout, XM_MD, XM_RD, stall, redirect, redirect_pc
  );

  modport slave (
    input  curr_state, MemtoReg, RegWrite, MemRead, MemWrite,
           branch, jump, Jal_swit, JR_swit, ALUctr,
           A, B, MD, JT, DX_PC, imm, RD,
    output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite,
           XM_ALUout, XM_MD, XM_RD, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage of the GCD CPU: single-cycle ALU, a 32-iteration shift-add
// multiplier that stalls the front end, and combinational beq/j/jal/jr
// redirect (one delay slot, no squash). Results land in the XM registers.
module execute_stage (
  input  logic          clk,
  input  logic          rst,
  execute_stage_if.slave ex
);

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Single-cycle ALU. Code 6 is the beq compare-subtract; its result is
  // the difference, the equality flag is derived separately.
  function automatic logic [DATA_W-1:0] alu_op(
    input logic [2:0]               ctr,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    case (ctr)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = (a < b) ? 32'd1 : 32'd0;
      3'd6:    r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] mcand, mcand_nxt;
  logic [DATA_W-1:0] mplier, mplier_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;

  logic              run;
  logic              is_mul;
  logic              zero;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_step;
  logic [DATA_W-1:0] branch_tgt;
  logic              xm_wr;
  logic [DATA_W-1:0] xm_result;
  logic              stall_c;

  assign run        = (ex.curr_state == 2'b01);
  assign is_mul     = (ex.ALUctr == 3'd5);
  assign zero       = (ex.A == ex.B);
  assign alu_res    = alu_op(ex.ALUctr, ex.A, ex.B);
  assign acc_step   = mplier[0] ? (acc + mcand) : acc;
  assign branch_tgt = ex.DX_PC + {{14{ex.imm[15]}}, ex.imm, 2'b00};

  // Next-state for the multiplier and the XM write decision.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    xm_wr      = 1'b0;
    xm_result  = alu_res;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (run && is_mul) begin
          stall_c    = 1'b1;
          mcand_nxt  = ex.A;
          mplier_nxt = ex.B;
          acc_nxt    = '0;
          cnt_nxt    = 5'd0;
          state_nxt  = MUL;
        end else if (run) begin
          xm_wr = 1'b1;
        end
      end
      MUL: begin
        // Front end stays frozen for the whole multiply, even while
        // the CPU is not running and the iteration is held.
        stall_c = (cnt != 5'd31) || !run;
        if (run) begin
          acc_nxt    = acc_step;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + 5'd1;
          if (cnt == 5'd31) begin
            xm_wr     = 1'b1;
            xm_result = acc_step;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ex.stall       = !rst && stall_c;
  assign ex.redirect    = !rst && run &&
                          (ex.JR_swit || ex.jump || ex.Jal_swit ||
                           (ex.branch && zero));
  assign ex.redirect_pc = (ex.JR_swit || ex.jump || ex.Jal_swit) ? ex.JT :
                          (ex.branch && zero) ? branch_tgt : '0;

  // Multiplier state register; reset aborts an in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
    end
  end

  // XM registers: load on a completing op, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex.XM_MemtoReg <= 1'b0;
      ex.XM_RegWrite <= 1'b0;
      ex.XM_MemRead  <= 1'b0;
      ex.XM_MemWrite <= 1'b0;
      ex.XM_ALUout   <= '0;
      ex.XM_MD       <= '0;
      ex.XM_RD       <= '0;
    end else if (xm_wr) begin
      ex.XM_MemtoReg <= ex.MemtoReg;
      ex.XM_RegWrite <= ex.RegWrite;
      ex.XM_MemRead  <= ex.MemRead;
      ex.XM_MemWrite <= ex.MemWrite;
      ex.XM_ALUout   <= xm_result;
      ex.XM_MD       <= ex.MD;
      ex.XM_RD       <= ex.RD;
    end else begin
      ex.XM_MemtoReg <= 1'b0;
      ex.XM_RegWrite <= 1'b0;
      ex.XM_MemRead  <= 1'b0;
      ex.XM_MemWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver issues DX instructions and
// queues the architectural result; a monitor pops on every XM write.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  aluctr;
    logic [31:0] a, b, md, jt, pc;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [3:0]  ctrl;   // {MemtoReg, RegWrite, MemRead, MemWrite}
    logic        br, jmp, jal, jr;
  } instr_t;

  typedef struct {
    logic [31:0] alu, md;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference ALU written straight from the instruction semantics.
  function automatic logic [31:0] model_alu(input instr_t in);
    case (in.aluctr)
      3'd0: return in.a + in.b;
      3'd1: return in.a - in.b;
      3'd2: return in.a & in.b;
      3'd3: return in.a | in.b;
      3'd4: return ($signed(in.a) < $signed(in.b)) ? 32'd1 : 32'd0;
      3'd5: return in.a * in.b;
      3'd6: return in.a - in.b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input instr_t in, input logic [1:0] st);
    bus.curr_state = st;
    bus.ALUctr     = in.aluctr;
    bus.A          = in.a;
    bus.B          = in.b;
    bus.MD         = in.md;
    bus.JT         = in.jt;
    bus.DX_PC      = in.pc;
    bus.imm        = in.imm;
    bus.RD         = in.rd;
    {bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite} = in.ctrl;
    bus.branch     = in.br;
    bus.jump       = in.jmp;
    bus.Jal_swit   = in.jal;
    bus.JR_swit    = in.jr;
  endtask

  function automatic instr_t nop_instr();
    instr_t n;
    n = '{aluctr: 3'd0, a: 0, b: 0, md: 0, jt: 0, pc: 0, imm: 0, rd: 0,
          ctrl: 4'b0, br: 0, jmp: 0, jal: 0, jr: 0};
    return n;
  endfunction

  // Present one instruction, check redirect, hold it through any stall.
  task automatic issue(input instr_t in);
    exp_t        e;
    logic        er;
    logic [31:0] epc;
    int          off;
    int          n;
    bit          is_mul;
    @(negedge clk);
    drive(in, 2'b01);
    is_mul = (in.aluctr == 3'd5);
    e.alu  = model_alu(in);
    e.md   = in.md;
    e.rd   = in.rd;
    e.ctrl = in.ctrl;
    e.cyc  = cyc + (is_mul ? 33 : 1);
    if (in.ctrl != 4'b0) q.push_back(e);
    off = $signed(in.imm);
    er  = 1'b0;
    epc = 32'd0;
    if (in.jr || in.jmp || in.jal) begin
      er  = 1'b1;
      epc = in.jt;
    end else if (in.br && (in.a == in.b)) begin
      er  = 1'b1;
      epc = in.pc + off * 4;
    end
    #1;
    check("redirect", bus.redirect, er);
    if (er) check("redirect_pc", bus.redirect_pc, epc);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, is_mul ? 32 : 0);
  endtask

  function automatic instr_t mk(input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    instr_t n;
    n = nop_instr();
    n.aluctr = c;
    n.a      = a;
    n.b      = b;
    n.rd     = rd;
    n.md     = $urandom;
    n.ctrl   = 4'b0100;
    return n;
  endfunction

  // Monitor: every cycle with a non-bubble XM is one retired instruction.
  always @(negedge clk) begin
    if (!rst && ({bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite} != 4'b0)) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got XM_ALUout %0h at cycle %0d, expected none", bus.XM_ALUout, cyc);
      end else begin
        mon_e = q.pop_front();
        check("XM_ALUout", bus.XM_ALUout, mon_e.alu);
        check("XM_MD", bus.XM_MD, mon_e.md);
        check("XM_RD", bus.XM_RD, mon_e.rd);
        check("XM_ctrl", {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite}, mon_e.ctrl);
        check("XM_latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    int     k;

    // Reset with a mul and a jump on the DX bus: both outputs must stay low.
    rst = 1'b1;
    t = nop_instr();
    t.aluctr = 3'd5;
    t.jmp = 1'b1;
    t.jt = 32'h44;
    drive(t, 2'b01);
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", bus.stall, 1'b0);
    check("reset_redirect", bus.redirect, 1'b0);
    check("reset_XM", {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite,
                       bus.XM_RD, bus.XM_ALUout[26:0]}, 36'd0);
    check("reset_XM_MD", bus.XM_MD, 32'd0);
    drive(nop_instr(), 2'b01);
    rst = 1'b0;

    // Directed cases.
    issue(mk(3'd0, 32'd5, 32'd7, 5'd3));
    issue(mk(3'd4, 32'hFFFF_FFFF, 32'd1, 5'd4));
    issue(mk(3'd5, 32'd7, 32'd6, 5'd5));
    issue(mk(3'd5, 32'hFFFF_FFFD, 32'd5, 5'd6));
    issue(mk(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7));
    issue(mk(3'd3, 32'hF000_0000, 32'h0000_000F, 5'd8));
    issue(mk(3'd1, 32'd0, 32'd1, 5'd9));
    t = mk(3'd6, 32'd9, 32'd9, 5'd0);
    t.br = 1'b1; t.pc = 32'h100; t.imm = 16'd3; t.ctrl = 4'b0000;
    issue(t);
    t.b = 32'd8;
    issue(t);
    t = mk(3'd6, 32'd9, 32'd9, 5'd0);
    t.br = 1'b1; t.pc = 32'h100; t.imm = 16'hFFFF;
    issue(t);
    t = mk(3'd0, 32'd1, 32'd2, 5'd0);
    t.jr = 1'b1; t.jt = 32'h40;
    issue(t);
    t = mk(3'd6, 32'd3, 32'd3, 5'd0);
    t.jmp = 1'b1; t.br = 1'b1; t.jt = 32'h200; t.pc = 32'h500; t.imm = 16'd1;
    issue(t);

    // Not running: bubble, no stall, no redirect.
    @(negedge clk);
    t = mk(3'd0, 32'd1, 32'd1, 5'd2);
    t.jmp = 1'b1; t.jt = 32'h80;
    drive(t, 2'b00);
    #1;
    check("halt_stall", bus.stall, 1'b0);
    check("halt_redirect", bus.redirect, 1'b0);
    @(negedge clk);
    check("halt_XM_RegWrite", bus.XM_RegWrite, 1'b0);

    // Back-to-back multiplies.
    issue(mk(3'd5, 32'd123456, 32'd789, 5'd10));
    issue(mk(3'd5, 32'h8000_0001, 32'h0000_0003, 5'd11));

    // Reset ten cycles into a multiply.
    @(negedge clk);
    drive(mk(3'd5, 32'd7, 32'd9, 5'd12), 2'b01);
    repeat (10) @(negedge clk);
    #1;
    check("mul_stall_before_reset", bus.stall, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_cycle_stall", bus.stall, 1'b0);
    @(negedge clk);
    check("abort_XM", {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite,
                       bus.XM_RD, bus.XM_ALUout[26:0]}, 36'd0);
    check("abort_XM_MD", bus.XM_MD, 32'd0);
    drive(nop_instr(), 2'b01);
    rst = 1'b0;
    #1;
    check("abort_stall", bus.stall, 1'b0);
    issue(mk(3'd0, 32'd5, 32'd7, 5'd3));

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 5);
      t = mk((k == 5) ? 3'd6 : 3'(k), $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 9) == 0) t.aluctr = 3'd5;
      if ($urandom_range(0, 3) == 0) t.b = t.a;
      t.ctrl = {1'($urandom), 1'b1, 1'($urandom), 1'($urandom)};
      t.pc   = $urandom;
      t.jt   = $urandom;
      t.imm  = 16'($urandom);
      if (t.aluctr != 3'd5) begin
        t.br  = ($urandom_range(0, 3) == 0);
        t.jmp = ($urandom_range(0, 7) == 0);
        t.jal = ($urandom_range(0, 7) == 0);
        t.jr  = ($urandom_range(0, 7) == 0);
      end
      issue(t);
    end

    @(negedge clk);
    drive(nop_instr(), 2'b01);
    repeat (3) @(negedge clk);
    check("pending_outputs", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline EX stage of the GCD CPU, directly downstream of instruction decode. Consumes the DX pipeline registers (operands, immediate, control bits, jump target) and performs the ALU operation, including an iterative 32-cycle multiply that stalls the front end. Latches results into the XM registers for the memory/writeback stage. Resolves beq/j/jal/jr combinationally into a fetch redirect with one architectural delay slot.

## Interface
- No parameters; widths fixed: 32-bit datapath, 5-bit register index, 3-bit ALUctr.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- curr_state  in  2  CPU run state; only 2'b01 (RUN) advances the stage
- MemtoReg, RegWrite, MemRead, MemWrite  in  1 each  DX control bits
- branch, jump, Jal_swit, JR_swit  in  1 each  DX beq / j / jal / jr flags
- ALUctr  in  3  0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 5 mul, 6 compare-sub
- A, B, MD, JT, DX_PC  in  32 each  rs value, rt-or-sign-extended-imm, store data, jump target, PC+4 of the DX instruction
- imm  in  16  raw immediate
- RD  in  5  destination register
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  out  1 each  registered control to MEM
- XM_ALUout, XM_MD  out  32 each  registered result and store data
- XM_RD  out  5  registered destination
- stall  out  1  combinational; upstream IF/ID must hold while high
- redirect  out  1  combinational; fetch loads redirect_pc this edge
- redirect_pc  out  32  combinational next-fetch address

## Operation
- run = (curr_state == 2'b01). When !run: XM control bits written 0 (bubble), stall = 0, redirect = 0, multiplier state held.
- Single-cycle ops (ALUctr != 5): XM_ALUout <= A op B (32-bit, wrap-around for add/sub; slt yields 32'd1/32'd0 on signed compare); XM_MD <= MD; XM_RD <= RD; XM control bits <= DX control bits.
- ALUctr 6: XM_ALUout <= A - B; zero = (A == B).
- Redirect priority: JR_swit, jump, Jal_swit -> redirect = 1, redirect_pc = JT. Otherwise branch && zero -> redirect = 1, redirect_pc = DX_PC + {sext(imm), 2'b00} (32-bit wrap). Otherwise 0.
- Multiplier FSM, states IDLE, MUL; 5-bit counter cnt; registers mcand, mplier, acc.
  - IDLE, run, ALUctr == 5: stall = 1; edge loads mcand = A, mplier = B, acc = 0, cnt = 0, -> MUL; XM control written as bubble.
  - MUL: each edge, if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; cnt += 1. stall = (cnt != 31).
  - MUL, cnt == 31: final iteration; XM_ALUout <= final acc (low 32 bits of A*B); XM_RD/control/MD from the still-held DX registers; -> IDLE.
  - MUL, !run: hold all state; stall = 0 is not permitted while MUL. Stall stays high except at cnt == 31.
- While stall high and not completing, XM control bits are bubbles (all 0).

## Timing
- Reset values: all XM outputs 0, FSM IDLE, cnt 0, mcand/mplier/acc 0. Outputs stall and redirect are 0 in reset cycle.
- Single-cycle op: XM outputs valid one edge after DX presentation.
- mul: stall high 32 consecutive cycles (entry + cnt 0..30), XM_ALUout valid at 33rd edge after presentation; next DX instruction accepted at that edge.
- Redirect is combinational from DX registers; the instruction already in ID (delay slot) executes normally, with no squash.
- Reset mid-multiply: abort, FSM IDLE next cycle, stall 0, no XM write.
- Back-to-back mul: second mul enters IDLE-start the cycle after completion.

## Test plan
- After reset, ALUctr 0, A=5, B=7, RegWrite=1, RD=3 -> one edge later XM_ALUout=12, XM_RD=3, XM_RegWrite=1; ALUctr 4, A=-1, B=1 -> XM_ALUout=1.
- ALUctr 5, A=7, B=6 -> stall high exactly 32 cycles, XM_ALUout=42 at 33rd edge; A=-3, B=5 -> 32'hFFFFFFF1.
- beq, A=B=9, DX_PC=32'h100, imm=3 -> redirect=1, redirect_pc=32'h10C; A=9, B=8 -> redirect=0.
- JR_swit=1, JT=32'h40 -> redirect=1, redirect_pc=32'h40; jump and branch both high -> JT wins.
- rst asserted at cycle 10 of a mul -> next cycle stall=0, all XM outputs 0; following add completes normally.
- curr_state=2'b00 with RegWrite=1 presented -> XM_RegWrite stays 0, stall=0, redirect=0.
